// File: rtl/pipe_pkg.sv
// Shared widths, encodings and constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;

    localparam int unsigned REG_DATA_W    = 32;
    localparam int unsigned ALU_OP_W      = 4;
    localparam int unsigned SHAMT_W       = 5;

    // rs1 data + rs2 data + sign-extended immediate + shamt
    localparam int unsigned ID_EXE_DATA_W = 3 * REG_DATA_W + SHAMT_W;
    // AluSrc1 + AluSrc + AluOperation
    localparam int unsigned ID_EXE_CTRL_W = 2 + ALU_OP_W;

    localparam logic [ID_EXE_CTRL_W-1:0] NOP_CTRL = '0;

    // Stage occupancy, encoded directly as {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'b00,
        ST_ONE       = 2'b01,
        ST_SKID_ONLY = 2'b10,
        ST_TWO       = 2'b11
    } stage_state_e;

    typedef enum logic {
        SRC_IN   = 1'b0,
        SRC_SKID = 1'b1
    } main_src_e;

    function automatic logic [1:0] entry_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline-register entry: a valid bit plus data and control bundles.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EXE_DATA_W,
    parameter int unsigned CTRL_W = ID_EXE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else begin
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
            if (load) begin
                data <= d_data;
                ctrl <= d_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready flow control,
// optional two-entry skid buffer, flush and hazard bubble insertion.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = ID_EXE_DATA_W,
    parameter int unsigned CTRL_W  = ID_EXE_CTRL_W,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              bubble,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              accept;
    logic              drain;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    main_src_e         main_src;
    stage_state_e      state;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;

    always_comb begin
        // With the skid entry, in_ready depends only on a flop; without it,
        // a full stage can still accept when the held beat leaves this cycle.
        if (SKID_EN) begin
            in_ready = !skid_valid;
        end else begin
            in_ready = !main_valid || out_ready;
        end

        accept     = in_valid && in_ready && !bubble && !flush;
        drain      = main_valid && out_ready && !flush;
        state      = stage_state_e'({skid_valid, main_valid});
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_src   = SRC_IN;

        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    main_load = accept;
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (drain) begin
                        main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_load  = 1'b1;
                        main_src   = SRC_SKID;
                        skid_clear = 1'b1;
                    end
                end
                ST_SKID_ONLY: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        if (main_src == SRC_SKID) begin
            main_d_data = skid_data;
            main_d_ctrl = skid_ctrl;
        end else begin
            main_d_data = in_data;
            main_d_ctrl = in_ctrl;
        end
    end

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .clear  (main_clear),
        .load   (main_load),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_valid),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_entry #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .clear  (skid_clear),
                .load   (skid_load),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .valid  (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
        end
    endgenerate

    // Downstream sees a NOP control word whenever nothing valid is held.
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_W'(NOP_CTRL);
    assign occupancy = entry_count(main_valid, skid_valid);

    skid_implies_main : assert property (@(posedge clk) disable iff (rst) skid_valid |-> main_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks of pipe_stage_reg with and without the skid entry.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = ID_EXE_DATA_W;
    localparam int unsigned CW = ID_EXE_CTRL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, flush, bubble, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;

    logic          in_valid_n, in_ready_n, flush_n, bubble_n, out_valid_n, out_ready_n;
    logic [DW-1:0] in_data_n, out_data_n;
    logic [CW-1:0] in_ctrl_n, out_ctrl_n;
    logic [1:0]    occupancy_n;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .bubble(bubble),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
        .in_data(in_data_n), .in_ctrl(in_ctrl_n), .flush(flush_n), .bubble(bubble_n),
        .out_valid(out_valid_n), .out_ready(out_ready_n), .out_data(out_data_n),
        .out_ctrl(out_ctrl_n), .occupancy(occupancy_n)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] v);
        return {v, v, v, v[4:0]};
    endfunction

    task automatic put(input logic v, input logic [31:0] val);
        in_valid = v;
        in_data  = mk(val);
        in_ctrl  = val[5:0];
    endtask

    task automatic put_n(input logic v, input logic [31:0] val);
        in_valid_n = v;
        in_data_n  = mk(val);
        in_ctrl_n  = val[5:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] val, input logic [1:0] occ);
        check({tag, ".valid"}, 128'(out_valid), 128'(v));
        check({tag, ".ctrl"}, 128'(out_ctrl), v ? 128'(val[5:0]) : 128'(0));
        check({tag, ".occ"}, 128'(occupancy), 128'(occ));
        if (v) check({tag, ".data"}, 128'(out_data), 128'(mk(val)));
    endtask

    logic [31:0] q1[$];
    logic [31:0] q0[$];
    logic [31:0] head;
    int unsigned seq1 = 0;
    int unsigned seq0 = 0;
    logic        acc;

    initial begin
        rst = 1'b1;
        flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;
        flush_n = 1'b0; bubble_n = 1'b0; out_ready_n = 1'b0;
        put(1'b0, 32'h0);
        put_n(1'b0, 32'h0);
        #12;
        check("rst.valid", 128'(out_valid), 128'(0));
        check("rst.data", 128'(out_data), 128'(0));
        check("rst.ctrl", 128'(out_ctrl), 128'(0));
        check("rst.occ", 128'(occupancy), 128'(0));
        check("rst.in_ready", 128'(in_ready), 128'(1));
        check("rst.in_ready_n", 128'(in_ready_n), 128'(1));
        check("rst.occ_n", 128'(occupancy_n), 128'(0));
        tick();
        rst = 1'b0;

        // Streaming at full rate
        out_ready = 1'b1;
        put(1'b1, 32'h11);
        check("stream.in_ready", 128'(in_ready), 128'(1));
        tick(); chk_out("stream1", 1'b1, 32'h11, 2'd1);
        put(1'b1, 32'h22);
        tick(); chk_out("stream2", 1'b1, 32'h22, 2'd1);
        put(1'b1, 32'h33);
        tick(); chk_out("stream3", 1'b1, 32'h33, 2'd1);
        put(1'b0, 32'h0);
        tick(); chk_out("stream_end", 1'b0, 32'h0, 2'd0);

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        put(1'b1, 32'h44);
        tick(); chk_out("bp1", 1'b1, 32'h44, 2'd1);
        check("bp1.in_ready", 128'(in_ready), 128'(1));
        put(1'b1, 32'h55);
        tick(); chk_out("bp2", 1'b1, 32'h44, 2'd2);
        check("bp2.in_ready", 128'(in_ready), 128'(0));
        put(1'b1, 32'h66);
        tick(); chk_out("bp3", 1'b1, 32'h44, 2'd2);
        check("bp3.in_ready", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        put(1'b0, 32'h0);
        tick(); chk_out("bp4", 1'b1, 32'h55, 2'd1);
        check("bp4.in_ready", 128'(in_ready), 128'(1));
        tick(); chk_out("bp5", 1'b0, 32'h0, 2'd0);

        // Flush from TWO and from ONE with a beat offered
        out_ready = 1'b0;
        put(1'b1, 32'h07); tick();
        put(1'b1, 32'h08); tick();
        chk_out("fl_full", 1'b1, 32'h07, 2'd2);
        put(1'b1, 32'h09); flush = 1'b1;
        tick(); flush = 1'b0;
        chk_out("fl_two", 1'b0, 32'h0, 2'd0);
        check("fl_two.in_ready", 128'(in_ready), 128'(1));
        put(1'b1, 32'h0A);
        tick(); chk_out("fl_load", 1'b1, 32'h0A, 2'd1);
        put(1'b1, 32'h0B); flush = 1'b1;
        tick(); flush = 1'b0;
        put(1'b0, 32'h0);
        chk_out("fl_one", 1'b0, 32'h0, 2'd0);
        tick(); chk_out("fl_after", 1'b0, 32'h0, 2'd0);

        // Bubble inserts a NOP downstream
        out_ready = 1'b1;
        put(1'b1, 32'h15);
        tick(); chk_out("bub0", 1'b1, 32'h15, 2'd1);
        put(1'b1, 32'h2A); bubble = 1'b1;
        tick(); bubble = 1'b0;
        chk_out("bub1", 1'b0, 32'h0, 2'd0);
        tick(); chk_out("bub2", 1'b1, 32'h2A, 2'd1);
        put(1'b0, 32'h0);
        tick(); chk_out("bub3", 1'b0, 32'h0, 2'd0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        put(1'b1, 32'h31); tick();
        put(1'b1, 32'h32); tick();
        chk_out("ar_full", 1'b1, 32'h31, 2'd2);
        put(1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("ar.valid", 128'(out_valid), 128'(0));
        check("ar.data", 128'(out_data), 128'(0));
        check("ar.ctrl", 128'(out_ctrl), 128'(0));
        check("ar.occ", 128'(occupancy), 128'(0));
        check("ar.in_ready", 128'(in_ready), 128'(1));
        #1 rst = 1'b0;
        put(1'b1, 32'h3C); out_ready = 1'b1;
        tick(); chk_out("ar_post", 1'b1, 32'h3C, 2'd1);
        put(1'b0, 32'h0);
        tick(); chk_out("ar_end", 1'b0, 32'h0, 2'd0);

        // Single-entry variant: combinational in_ready
        out_ready_n = 1'b0;
        put_n(1'b1, 32'h51);
        tick();
        check("ns.valid", 128'(out_valid_n), 128'(1));
        check("ns.data", 128'(out_data_n), 128'(mk(32'h51)));
        check("ns.occ", 128'(occupancy_n), 128'(1));
        check("ns.rdy_lo", 128'(in_ready_n), 128'(0));
        out_ready_n = 1'b1; #1;
        check("ns.rdy_comb_hi", 128'(in_ready_n), 128'(1));
        out_ready_n = 1'b0; #1;
        check("ns.rdy_comb_lo", 128'(in_ready_n), 128'(0));
        put_n(1'b1, 32'h52);
        tick();
        check("ns.hold", 128'(out_data_n), 128'(mk(32'h51)));
        check("ns.hold_occ", 128'(occupancy_n), 128'(1));
        out_ready_n = 1'b1;
        tick();
        check("ns.swap", 128'(out_data_n), 128'(mk(32'h52)));
        check("ns.swap_ctrl", 128'(out_ctrl_n), 128'(6'h12));
        put_n(1'b0, 32'h0);
        tick();
        check("ns.empty", 128'(out_valid_n), 128'(0));
        check("ns.empty_ctrl", 128'(out_ctrl_n), 128'(0));

        // Random valid/ready traffic against queue models for both variants
        for (int unsigned cyc = 0; cyc < 10000 && errors < 50; cyc++) begin
            put(($urandom_range(0, 3) != 0), 32'(seq1));
            bubble    = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            put_n(($urandom_range(0, 3) != 0), 32'(seq0));
            out_ready_n = ($urandom_range(0, 2) != 0);
            @(negedge clk);

            check("r1.rdy", 128'(in_ready), 128'(q1.size() < 2));
            check("r1.occ", 128'(occupancy), 128'(q1.size()));
            if (q1.size() == 0) begin
                check("r1.valid", 128'(out_valid), 128'(0));
                check("r1.nop", 128'(out_ctrl), 128'(0));
            end else begin
                head = q1[0];
                check("r1.valid", 128'(out_valid), 128'(1));
                check("r1.data", 128'(out_data), 128'(mk(head)));
                check("r1.ctrl", 128'(out_ctrl), 128'(head[5:0]));
            end
            acc = in_valid && (q1.size() < 2) && !bubble;
            if (out_ready && q1.size() != 0) void'(q1.pop_front());
            if (acc) begin
                q1.push_back(32'(seq1));
                seq1++;
            end

            check("r0.rdy", 128'(in_ready_n), 128'((q0.size() == 0) || out_ready_n));
            check("r0.occ", 128'(occupancy_n), 128'(q0.size()));
            if (q0.size() == 0) begin
                check("r0.valid", 128'(out_valid_n), 128'(0));
                check("r0.nop", 128'(out_ctrl_n), 128'(0));
            end else begin
                head = q0[0];
                check("r0.valid", 128'(out_valid_n), 128'(1));
                check("r0.data", 128'(out_data_n), 128'(mk(head)));
                check("r0.ctrl", 128'(out_ctrl_n), 128'(head[5:0]));
            end
            acc = in_valid_n && ((q0.size() == 0) || out_ready_n);
            if (out_ready_n && q0.size() != 0) void'(q0.pop_front());
            if (acc) begin
                q0.push_back(32'(seq0));
                seq0++;
            end

            @(posedge clk);
            #1;
        end

        put(1'b0, 32'h0);
        put_n(1'b0, 32'h0);
        bubble = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the MIPS pipeline: replaces the fixed, always-loading ID→EXE register with a generic stage usable at IF/ID, ID/EXE, EXE/MEM and MEM/WB. Carries a data bundle and a control bundle with valid/ready flow control, optional two-entry skid buffering, synchronous flush and bubble insertion. Control outputs are forced to zero whenever the stage holds no valid instruction, so downstream logic always sees a NOP.

## Interface
- DATA_W, 101, width of data bundle (e.g. rs1 data 32 + rs2 data 32 + sign-extended immediate 32 + shamt 5)
- CTRL_W, 6, width of control bundle (e.g. AluSrc1 1 + AluSrc 1 + AluOperation 4)
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- in_data  input  DATA_W  upstream data bundle
- in_ctrl  input  CTRL_W  upstream control bundle
- flush  input  1  discard all held entries (branch mispredict / exception)
- bubble  input  1  hazard unit: suppress acceptance this cycle, treating the input as a NOP
- out_valid  output  1  stage holds a valid instruction
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  held data bundle
- out_ctrl  output  CTRL_W  held control bundle; all-zero when out_valid = 0
- occupancy  output  2  entries held (0..2; max 1 when SKID_EN = 0)

## Operation
- Accept = in_valid & in_ready & !bubble & !flush. Drain = out_valid & out_ready.
- Entries: main (drives the outputs) and skid (SKID_EN = 1 only). Each has a valid bit plus data/ctrl registers.
- States (SKID_EN = 1): EMPTY, ONE, TWO; encoded by the main and skid valid bits.
  - EMPTY: if accept, load main → ONE.
  - ONE:
    - accept & drain: reload main → ONE.
    - accept & !drain: load skid → TWO.
    - drain only → EMPTY.
    - otherwise hold.
  - TWO: in_ready = 0. On drain, move skid to main → ONE. Otherwise hold.
- in_ready, SKID_EN = 1: !skid_valid. Registered; no combinational path from out_ready.
- in_ready, SKID_EN = 0: !main_valid | out_ready. Combinational from out_ready.
- flush: clears both valid bits on the next edge and overrides accept and drain in the same cycle. Data registers need not be cleared.
- bubble: blocks acceptance only. Held entries still drain normally, so an inserted NOP appears downstream as out_valid = 0.
- out_ctrl = main_valid ? main_ctrl : 0. out_data shows main_data regardless of valid.
- occupancy = main_valid + skid_valid.
- Invariant: skid_valid implies main_valid. A violation is an assertion failure.

## Timing
- Reset, asynchronous: main/skid valid = 0, data/ctrl registers = 0. Hence out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0.
- Reset, in_ready: 1 when SKID_EN = 1; out_ready-independent 1 when SKID_EN = 0.
- Reset asserted mid-transfer: entries are lost immediately. The first accept after reset release lands on the next rising edge.
- Latency: 1 cycle in_valid → out_valid when the stage is empty. Throughput is 1 per cycle under continuous out_ready.
- Backpressure, SKID_EN = 1: in_ready deasserts the cycle after TWO is reached. At most one extra beat is absorbed after out_ready falls.
- flush and rst together: rst dominates. flush and bubble together: flush dominates; the net effect is the same.

## Structure
- Shared package pipe_pkg holds:
  - per-stage DATA_W/CTRL_W constants: ID_EXE_DATA_W = 101, ID_EXE_CTRL_W = 6;
  - the ALU operation width (4) and the shamt width (5);
  - the NOP control constant (all zero).
- One natural sub-module: pipe_entry, a valid + data + ctrl register with load and clear. Instantiate it twice (main, skid); the skid instance is generated only when SKID_EN = 1.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with out_ready = 1 → outputs appear at cycles 1, 2, 3 in order; occupancy stays at 1.
- SKID_EN = 1 with out_ready held at 0 → two beats are accepted, in_ready = 0 from cycle 2, occupancy = 2. Releasing out_ready yields the beats in order with none lost or duplicated.
- flush in state TWO while in_valid = 1 → the next cycle has out_valid = 0, out_ctrl = 0, occupancy = 0, and the input beat is not captured.
- bubble for one cycle while in_valid = 1 with ctrl 0x2A → that cycle's beat is not taken. The downstream sees one out_valid = 0 cycle with out_ctrl = 0, then 0x2A the following cycle.
- Assert rst asynchronously between edges while occupancy = 2 → all outputs are 0 immediately, before the next edge.
- SKID_EN = 0 → in_ready tracks out_ready combinationally when full; run a randomized valid/ready scoreboard for 10k cycles with no loss or reordering.
